// File: rtl/lpm_pkg.sv
// Shared LPM types: the {a,b,c} payload triple, payload width, clog2 helper.
package lpm_pkg;

  typedef struct packed {
    logic [31:0] c;
    logic [31:0] b;
    logic [31:0] a;
  } lpm_triple_t;

  localparam int LPM_WIDTH = 96;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/lpm_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr, wrapping.
module lpm_rr_pick
  import lpm_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [TAGW-1:0] i_rr,
  output logic [TAGW-1:0] o_idx,
  output logic            o_found
);

  int w_j;

  // Scan from farthest to nearest so the closest request to rr wins last.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = int'(i_rr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (i_req[w_j]) begin
        o_idx   = TAGW'(w_j);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lpm_req_arbiter.sv
// Round-robin arbiter feeding one holding register into a shared FIFO.
// Define LPM_ARB_STATS_EN to add per-requester grant and stall counters.
module lpm_req_arbiter
  import lpm_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = LPM_WIDTH,
  parameter int TAGW  = clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       req_enq__ENA,
  input  logic [NREQ*WIDTH-1:0] req_enq_v,
  output logic [NREQ-1:0]       req_enq__RDY,
  output logic                  out_enq__ENA,
  output logic [WIDTH-1:0]      out_enq_v,
  output logic [TAGW-1:0]       out_enq_tag,
  input  logic                  out_enq__RDY
`ifdef LPM_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]    stat_grants,
  output logic [15:0]           stat_stall
`endif
);

  logic             r_hvalid;
  logic [WIDTH-1:0] r_hdata;
  logic [TAGW-1:0]  r_htag;
  logic [TAGW-1:0]  r_rr;

  logic             w_pop;
  logic             w_accept;
  logic             w_xfer;
  logic [TAGW-1:0]  w_g;
  logic             w_found;

  assign w_pop    = r_hvalid & out_enq__RDY;
  assign w_accept = !r_hvalid | w_pop;
  assign w_xfer   = w_found & w_accept;

  lpm_rr_pick #(
    .NREQ(NREQ),
    .TAGW(TAGW)
  ) u_pick (
    .i_req  (req_enq__ENA),
    .i_rr   (r_rr),
    .o_idx  (w_g),
    .o_found(w_found)
  );

  always_comb begin
    req_enq__RDY = '0;
    if (w_found) req_enq__RDY[w_g] = w_accept;
  end

  assign out_enq__ENA = r_hvalid;
  assign out_enq_v    = r_hdata;
  assign out_enq_tag  = r_htag;

  // A transfer overrides a same-cycle pop, so there is no bubble.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_hvalid <= 1'b0;
      r_hdata  <= '0;
      r_htag   <= '0;
      r_rr     <= '0;
    end else if (w_xfer) begin
      r_hvalid <= 1'b1;
      r_hdata  <= req_enq_v[int'(w_g)*WIDTH +: WIDTH];
      r_htag   <= w_g;
      r_rr     <= (w_g == TAGW'(NREQ - 1)) ? '0 : w_g + 1'b1;
    end else if (w_pop) begin
      r_hvalid <= 1'b0;
    end
  end

`ifdef LPM_ARB_STATS_EN
  logic [NREQ-1:0][15:0] r_grants;
  logic [15:0]           r_stall;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_grants <= '0;
      r_stall  <= '0;
    end else begin
      if (w_xfer && r_grants[w_g] != 16'hFFFF)
        r_grants[w_g] <= r_grants[w_g] + 16'd1;
      if (r_hvalid && !out_enq__RDY && r_stall != 16'hFFFF)
        r_stall <= r_stall + 16'd1;
    end
  end

  assign stat_grants = r_grants;
  assign stat_stall  = r_stall;
`endif

endmodule

// File: tb/tb_lpm_req_arbiter.sv
// Directed bench for lpm_req_arbiter (4 requesters, 96-bit payload).
module tb_lpm_req_arbiter;
  import lpm_pkg::*;

  logic         clk;
  logic         nrst;
  logic [3:0]   ena;
  logic [383:0] vin;
  logic [3:0]   rdy_o;
  logic         oena;
  logic [95:0]  ov;
  logic [1:0]   otag;
  logic         fifo_rdy;
`ifdef LPM_ARB_STATS_EN
  logic [63:0]  grants;
  logic [15:0]  stall;
`endif

  int n_chk = 0;
  int n_err = 0;

  lpm_req_arbiter dut (
    .CLK         (clk),
    .nRST        (nrst),
    .req_enq__ENA(ena),
    .req_enq_v   (vin),
    .req_enq__RDY(rdy_o),
    .out_enq__ENA(oena),
    .out_enq_v   (ov),
    .out_enq_tag (otag),
    .out_enq__RDY(fifo_rdy)
`ifdef LPM_ARB_STATS_EN
    ,
    .stat_grants (grants),
    .stat_stall  (stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] mk(input int i);
    return {32'(i * 3 + 3), 32'(i * 3 + 2), 32'(i * 3 + 1)};
  endfunction

  initial begin
    nrst     = 1'b0;
    ena      = '0;
    vin      = '0;
    fifo_rdy = 1'b1;
    tick();
    tick();
    check("rst_ena", 128'(oena), 128'(0));
    check("rst_v", 128'(ov), 128'(0));
    check("rst_tag", 128'(otag), 128'(0));
    ena = 4'b1010;
    #1;
    check("rst_rdy", 128'(rdy_o), 128'(4'b0010));
    ena = '0;
    #1;
    nrst = 1'b1;
    tick();

    // single requester
    vin[2*96 +: 96] = {32'd3, 32'd2, 32'd1};
    ena = 4'b0100;
    #1;
    check("one_rdy", 128'(rdy_o), 128'(4'b0100));
    tick();
    ena = '0;
    #1;
    check("one_ena", 128'(oena), 128'(1));
    check("one_tag", 128'(otag), 128'(2));
    check("one_v", 128'(ov), 128'({32'd3, 32'd2, 32'd1}));
    ena = 4'b1111;
    #1;
    check("one_rr3", 128'(rdy_o), 128'(4'b1000));
    ena = '0;
    tick();
    check("one_pop", 128'(oena), 128'(0));

    // all four, round robin from rr=0
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) vin[i*96 +: 96] = mk(i);
    ena = 4'b1111;
    #1;
    check("rr_first", 128'(rdy_o), 128'(4'b0001));
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rr_tag%0d", k), 128'(otag), 128'(k % 4));
      check($sformatf("rr_ena%0d", k), 128'(oena), 128'(1));
      check($sformatf("rr_v%0d", k), 128'(ov), 128'(mk(k % 4)));
    end

    // backpressure on held tag 3
    fifo_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_rdy%0d", k), 128'(rdy_o), 128'(0));
      check($sformatf("bp_v%0d", k), 128'(ov), 128'(mk(3)));
      check($sformatf("bp_ena%0d", k), 128'(oena), 128'(1));
      tick();
    end
    fifo_rdy = 1'b1;
    #1;
    check("bp_rel_rdy", 128'(rdy_o), 128'(4'b0001));
    tick();
    check("bp_rel_tag", 128'(otag), 128'(0));
    check("bp_rel_ena", 128'(oena), 128'(1));
    ena = '0;
    tick();
    check("bp_drain", 128'(oena), 128'(0));

    // wrap-around: rr=1 now, grant 2 to move rr to 3
    ena = 4'b0100;
    tick();
    ena = 4'b1001;
    #1;
    check("wr_rdy3", 128'(rdy_o), 128'(4'b1000));
    tick();
    check("wr_tag3", 128'(otag), 128'(3));
    #1;
    check("wr_rdy0", 128'(rdy_o), 128'(4'b0001));
    tick();
    check("wr_tag0", 128'(otag), 128'(0));
    ena = 4'b1111;
    #1;
    check("wr_rr1", 128'(rdy_o), 128'(4'b0010));
    ena = '0;
    tick();
    check("wr_drain", 128'(oena), 128'(0));

    // reset mid-operation with a stalled entry
    vin[2*96 +: 96] = mk(7);
    ena = 4'b0100;
    tick();
    ena = '0;
    fifo_rdy = 1'b0;
    tick();
    check("mr_held", 128'(oena), 128'(1));
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    check("mr_ena", 128'(oena), 128'(0));
    check("mr_v", 128'(ov), 128'(0));
    check("mr_tag", 128'(otag), 128'(0));
    ena = 4'b1111;
    #1;
    check("mr_rr0", 128'(rdy_o), 128'(4'b0001));
    ena = '0;
    fifo_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mr_gone%0d", k), 128'(oena), 128'(0));
    end

`ifdef LPM_ARB_STATS_EN
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    ena = 4'b0010;
    for (int k = 0; k < 3; k++) tick();
    ena = '0;
    fifo_rdy = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    fifo_rdy = 1'b1;
    check("st_g1", 128'(grants[16 +: 16]), 128'(3));
    check("st_g0", 128'(grants[0 +: 16]), 128'(0));
    check("st_stall", 128'(stall), 128'(4));
    ena = 4'b0010;
    for (int k = 0; k < 65532; k++) @(posedge clk);
    #1;
    check("st_max", 128'(grants[16 +: 16]), 128'(16'hFFFF));
    tick();
    check("st_sat", 128'(grants[16 +: 16]), 128'(16'hFFFF));
    ena = '0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
